ycfsm_sequencer: RTL and testbench
==================================

# ycfsm_sequencer

Clocked controller that sequences a row of `WIDTH` asynchronous Morphle Logic yellow cells (ycfsm) through complete dual-rail, return-to-empty transactions. It performs these steps in order:
- pulses the row's reset;
- drives the `in` and `match` rails with a value wavefront;
- waits for every `out` rail to become full;
- captures the result;
- drives the empty wavefront and waits for every `out` rail to return to empty.

It sits between the synchronous host/configuration logic and the self-timed cell fabric. Dual-rail encoding is fixed: Vempty = 2'b00, V0 = 2'b01, V1 = 2'b10; 2'b11 is illegal.

## Interface
Parameters:
- WIDTH, 8, number of ycfsm cells driven in parallel.
- RST_CYCLES, 4, number of clk cycles `blk_reset` is held high; must be ≥1.
- TIMEOUT, 255, maximum cycles spent in either wait state before an error; must be ≥4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  request one transaction; accepted only in IDLE.
- do_reset  in  1  request a fabric reset before the transaction; sampled together with an accepted start.
- in_bits  in  WIDTH  `in` values, captured when start is accepted.
- match_bits  in  WIDTH  `match` values, captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transaction completes successfully.
- error  out  1  sticky; set on timeout or illegal rail; cleared by reset or by an accepted start.
- result_bits  out  WIDTH  captured output values; bit = 1 when the rail was V1.
- blk_reset  out  1  drives the `reset` input of every cell.
- blk_in  out  2*WIDTH  dual-rail `in`; cell i uses [2i+1:2i].
- blk_match  out  2*WIDTH  dual-rail `match`; same packing as blk_in.
- blk_out  in  2*WIDTH  dual-rail `out` from the cells; asynchronous, same packing.

## Operation
- blk_out passes through a 2-flop synchronizer, giving `sout`. All decisions use `sout`.
- Per-cell flags from `sout`: full = rail is V0 or V1; empty = 00; illegal = 11.
- States: IDLE, BRESET, DRIVE, WAIT_FULL, DRAIN, WAIT_EMPTY, ERR.
- IDLE: blk_in = blk_match = all Vempty; blk_reset = 0.
  - On start: latch in_bits and match_bits, clear error.
  - Go to BRESET if do_reset is high, else to DRIVE.
- BRESET: blk_reset = 1 for exactly RST_CYCLES cycles, with rails empty, then go to DRIVE.
- DRIVE: for one cycle, set blk_in[i] = latched in_bit ? V1 : V0 and blk_match[i] the same way from match_bits; then go to WAIT_FULL.
  - blk_in and blk_match are registered and hold their value through WAIT_FULL.
- WAIT_FULL: completes when all cells are full for 2 consecutive cycles with identical `sout` in both.
  - On completion: result_bits[i] = sout[2i+1]; go to DRAIN.
- DRAIN: set blk_in and blk_match to all Vempty; go to WAIT_EMPTY.
- WAIT_EMPTY: completes when all cells are empty for 2 consecutive cycles.
  - On completion: pulse done; go to IDLE.
- Error conditions:
  - any illegal cell in WAIT_FULL or WAIT_EMPTY;
  - the wait-cycle counter reaching TIMEOUT.
- On an error: set error; go to ERR.
  - ERR drives blk_reset = 1 and empty rails for RST_CYCLES cycles, then goes to IDLE. done is not pulsed.
- The wait-cycle counter is $clog2(TIMEOUT+1) bits wide. It clears on entry to each wait state and saturates; it never wraps.
- start is ignored while busy; there is no queueing.

## Timing
- Reset values:
  - state = IDLE; busy = 0; done = 0; error = 0;
  - result_bits = 0; blk_reset = 0;
  - blk_in = blk_match = all 00;
  - synchronizer flops = 0; counter = 0.
- reset has priority over every state, including mid-transaction and ERR.
  - Rails go empty on the following edge.
  - blk_reset is not asserted by reset alone.
- start accepted at edge T:
  - busy = 1 from T;
  - with do_reset, blk_reset is high for edges T..T+RST_CYCLES-1;
  - blk_in becomes valid one edge after the last BRESET cycle, or at T+1 without do_reset.
- Minimum response latency, for a fabric that responds instantly: blk_in valid → result captured ≥ 4 cycles (2 synchronizer cycles + 2 stability cycles).
- Minimum transaction without do_reset: start → done ≥ 10 cycles. busy falls on the same edge that done rises.
- result_bits changes only on WAIT_FULL completion and holds until the next completion.
- A value changing between two full samples (glitch or partial wavefront) restarts the 2-cycle stability check; the timeout counter is not reset.

## Test plan
- Reset then idle: after reset, all outputs are at reset values. start=0 for 20 cycles leaves busy = 0 and rails at 00.
- Single transaction with fabric model out = in when match == in, else Vempty-held:
  - WIDTH=8, do_reset=1, in_bits=8'hA5, match_bits=8'hA5;
  - blk_reset high for exactly 4 cycles;
  - result_bits = 8'hA5; done pulses once; rails return to 00.
- Back-to-back transactions:
  - in=8'hFF, then 8'h00 with start held high;
  - second transaction starts the cycle after done;
  - results 8'hFF then 8'h00; no start is lost or duplicated.
- Timeout: fabric holds cell 3 empty.
  - error is set after TIMEOUT cycles in WAIT_FULL;
  - ERR pulses blk_reset for 4 cycles; no done; busy returns to 0.
  - A subsequent good start clears error.
- Illegal rail: fabric drives cell 0 to 2'b11 during WAIT_EMPTY → error within 3 cycles; no done.
- Reset mid-WAIT_FULL: assert reset for one cycle → next edge shows IDLE, rails 00, busy = 0, result_bits = 0.

Source files
------------

// File: rtl/ycfsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ycfsm_sequencer
// Purpose  : Drives a row of self-timed ycfsm cells through dual-rail,
//            return-to-empty transactions from a synchronous host.
// Revision : 1.0 - initial release
// ============================================================================
module ycfsm_sequencer #(
    parameter int WIDTH      = 8,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 do_reset,
    input  logic [WIDTH-1:0]     in_bits,
    input  logic [WIDTH-1:0]     match_bits,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result_bits,
    output logic                 blk_reset,
    output logic [2*WIDTH-1:0]   blk_in,
    output logic [2*WIDTH-1:0]   blk_match,
    input  logic [2*WIDTH-1:0]   blk_out
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [RW-1:0] RMAX = RW'(RST_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BRESET     = 3'd1,
        S_DRIVE      = 3'd2,
        S_WAIT_FULL  = 3'd3,
        S_DRAIN      = 3'd4,
        S_WAIT_EMPTY = 3'd5,
        S_ERR        = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               blk_reset_q, blk_reset_d;
    logic [2*WIDTH-1:0] blk_in_q, blk_in_d;
    logic [2*WIDTH-1:0] blk_match_q, blk_match_d;
    logic [WIDTH-1:0]   in_lat_q, in_lat_d;
    logic [WIDTH-1:0]   match_lat_q, match_lat_d;
    logic [2*WIDTH-1:0] sync1_q, sout_q, sprev_q;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;

    logic               all_full, all_empty, any_illegal, same;
    logic [2*WIDTH-1:0] in_rails, match_rails;

    always_comb begin
        all_full    = 1'b1;
        all_empty   = 1'b1;
        any_illegal = 1'b0;
        in_rails    = '0;
        match_rails = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (sout_q[2*i +: 2])
                2'b00:   all_full = 1'b0;
                2'b11: begin
                    any_illegal = 1'b1;
                    all_full    = 1'b0;
                    all_empty   = 1'b0;
                end
                default: all_empty = 1'b0;
            endcase
            in_rails[2*i +: 2]    = in_lat_q[i]    ? 2'b10 : 2'b01;
            match_rails[2*i +: 2] = match_lat_q[i] ? 2'b10 : 2'b01;
        end
        // A wavefront counts as settled only once two successive samples agree.
        same = (sout_q == sprev_q);
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        error_d     = error_q;
        result_d    = result_q;
        blk_reset_d = 1'b0;
        blk_in_d    = blk_in_q;
        blk_match_d = blk_match_q;
        in_lat_d    = in_lat_q;
        match_lat_d = match_lat_q;
        wcnt_d      = (wcnt_q == TMAX) ? wcnt_q : wcnt_q + 1'b1;
        rcnt_d      = rcnt_q;

        case (state_q)
            S_IDLE: begin
                blk_in_d    = '0;
                blk_match_d = '0;
                if (start) begin
                    in_lat_d    = in_bits;
                    match_lat_d = match_bits;
                    error_d     = 1'b0;
                    if (do_reset) begin
                        state_d     = S_BRESET;
                        blk_reset_d = 1'b1;
                        rcnt_d      = RW'(1);
                    end else begin
                        state_d = S_DRIVE;
                    end
                end
            end
            S_BRESET, S_ERR: begin
                blk_in_d    = '0;
                blk_match_d = '0;
                if (rcnt_q >= RMAX) begin
                    state_d = (state_q == S_BRESET) ? S_DRIVE : S_IDLE;
                end else begin
                    blk_reset_d = 1'b1;
                    rcnt_d      = rcnt_q + 1'b1;
                end
            end
            S_DRIVE: begin
                blk_in_d    = in_rails;
                blk_match_d = match_rails;
                wcnt_d      = '0;
                state_d     = S_WAIT_FULL;
            end
            S_WAIT_FULL: begin
                if (any_illegal || (!(all_full && same) && wcnt_q == TMAX)) begin
                    state_d     = S_ERR;
                    error_d     = 1'b1;
                    blk_reset_d = 1'b1;
                    rcnt_d      = RW'(1);
                    blk_in_d    = '0;
                    blk_match_d = '0;
                end else if (all_full && same) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        result_d[i] = sout_q[2*i+1];
                    end
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                blk_in_d    = '0;
                blk_match_d = '0;
                wcnt_d      = '0;
                state_d     = S_WAIT_EMPTY;
            end
            S_WAIT_EMPTY: begin
                if (any_illegal || (!(all_empty && same) && wcnt_q == TMAX)) begin
                    state_d     = S_ERR;
                    error_d     = 1'b1;
                    blk_reset_d = 1'b1;
                    rcnt_d      = RW'(1);
                end else if (all_empty && same) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                blk_in_d    = '0;
                blk_match_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            blk_reset_q <= 1'b0;
            blk_in_q    <= '0;
            blk_match_q <= '0;
            in_lat_q    <= '0;
            match_lat_q <= '0;
            sync1_q     <= '0;
            sout_q      <= '0;
            sprev_q     <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            result_q    <= result_d;
            blk_reset_q <= blk_reset_d;
            blk_in_q    <= blk_in_d;
            blk_match_q <= blk_match_d;
            in_lat_q    <= in_lat_d;
            match_lat_q <= match_lat_d;
            sync1_q     <= blk_out;
            sout_q      <= sync1_q;
            sprev_q     <= sout_q;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign result_bits = result_q;
    assign blk_reset   = blk_reset_q;
    assign blk_in      = blk_in_q;
    assign blk_match   = blk_match_q;

endmodule
`default_nettype wire

// File: tb/tb_ycfsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycfsm_sequencer
// Purpose  : Self-checking bench for ycfsm_sequencer with a behavioural
//            cell-row model answering out = in when match == in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ycfsm_sequencer;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           reset, start, do_reset;
    logic [W-1:0]   in_bits, match_bits;
    logic           busy, done, error, blk_reset;
    logic [W-1:0]   result_bits;
    logic [2*W-1:0] blk_in, blk_match, blk_out;

    logic [W-1:0]   hold_empty;
    logic           inj_illegal;

    int tests = 0;
    int fails = 0;

    ycfsm_sequencer #(.WIDTH(W), .RST_CYCLES(R), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .do_reset    (do_reset),
        .in_bits     (in_bits),
        .match_bits  (match_bits),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .result_bits (result_bits),
        .blk_reset   (blk_reset),
        .blk_in      (blk_in),
        .blk_match   (blk_match),
        .blk_out     (blk_out)
    );

    always #5 clk = ~clk;

    // Cell row: each cell echoes its in rail once match agrees, else stays empty.
    always_comb begin
        blk_out = '0;
        for (int i = 0; i < W; i++) begin
            if (!blk_reset && !hold_empty[i] && blk_in[2*i +: 2] == blk_match[2*i +: 2])
                blk_out[2*i +: 2] = blk_in[2*i +: 2];
        end
        if (inj_illegal) blk_out[1:0] = 2'b11;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic run_txn(input logic [W-1:0] iv, input logic [W-1:0] mv, input logic dr,
                           output int n_rst, output int n_done, output int lat,
                           output int err_cyc, output logic hung);
        int cyc;
        in_bits = iv; match_bits = mv; do_reset = dr; start = 1'b1;
        tick;
        start = 1'b0; do_reset = 1'b0;
        check("busy_on_accept", 64'(busy), 64'(1));
        check("error_clear_on_accept", 64'(error), 64'(0));
        cyc = 0; n_rst = int'(blk_reset); n_done = 0; lat = -1; err_cyc = -1;
        while (busy && cyc < 3000) begin
            tick;
            cyc++;
            n_rst += int'(blk_reset);
            if (done) begin n_done++; lat = cyc; end
            if (error && err_cyc < 0) err_cyc = cyc;
        end
        hung = busy;
    endtask

    task automatic expect_txn(input string tag, input logic [W-1:0] iv, input logic [W-1:0] mv,
                              input logic dr, input logic ok, input logic [W-1:0] exp_res);
        int n_rst, n_done, lat, err_cyc;
        logic hung;
        run_txn(iv, mv, dr, n_rst, n_done, lat, err_cyc, hung);
        check({tag, "_hang"}, 64'(hung), 64'(0));
        check({tag, "_done"}, 64'(n_done), ok ? 64'(1) : 64'(0));
        check({tag, "_error"}, 64'(error), ok ? 64'(0) : 64'(1));
        check({tag, "_result"}, 64'(result_bits), 64'(exp_res));
        check({tag, "_rst_cycles"}, 64'(n_rst), 64'((dr ? R : 0) + (ok ? 0 : R)));
        check({tag, "_rails_empty"}, 64'({blk_in, blk_match}), 64'(0));
        if (ok) check_range({tag, "_latency"}, lat, dr ? 10 + R : 10, 60);
        else    check_range({tag, "_timeout_at"}, err_cyc, TO, TO + R + 12);
    endtask

    typedef struct {
        logic [W-1:0] iv;
        logic [W-1:0] mv;
        logic         dr;
        logic         ok;
        logic [W-1:0] res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, nd, inj_c, err_c;
        logic saw, bad;
        logic [W-1:0] iv, mv, last_res;
        logic dr, ok;

        vecs[0] = '{iv: 8'hA5, mv: 8'hA5, dr: 1'b1, ok: 1'b1, res: 8'hA5};
        vecs[1] = '{iv: 8'hFF, mv: 8'hFF, dr: 1'b0, ok: 1'b1, res: 8'hFF};
        vecs[2] = '{iv: 8'h00, mv: 8'h00, dr: 1'b0, ok: 1'b1, res: 8'h00};
        vecs[3] = '{iv: 8'h3C, mv: 8'h3C, dr: 1'b1, ok: 1'b1, res: 8'h3C};
        vecs[4] = '{iv: 8'h0F, mv: 8'h0E, dr: 1'b0, ok: 1'b0, res: 8'h3C};
        vecs[5] = '{iv: 8'h5A, mv: 8'h5A, dr: 1'b0, ok: 1'b1, res: 8'h5A};

        reset = 1'b1; start = 1'b0; do_reset = 1'b0;
        in_bits = '0; match_bits = '0; hold_empty = '0; inj_illegal = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_result", 64'(result_bits), 64'(0));
        check("rst_blk_reset", 64'(blk_reset), 64'(0));
        check("rst_rails", 64'({blk_in, blk_match}), 64'(0));

        bad = 1'b0;
        repeat (20) begin
            tick;
            if (busy || blk_reset || blk_in != '0 || blk_match != '0) bad = 1'b1;
        end
        check("idle_quiet", 64'(bad), 64'(0));

        for (int k = 0; k < 6; k++)
            expect_txn($sformatf("vec%0d", k), vecs[k].iv, vecs[k].mv, vecs[k].dr,
                       vecs[k].ok, vecs[k].res);

        // Cell 3 never fills: timeout, then a good start recovers.
        hold_empty = 8'h08;
        expect_txn("timeout", 8'h77, 8'h77, 1'b0, 1'b0, 8'h5A);
        hold_empty = '0;
        expect_txn("recover", 8'hC3, 8'hC3, 1'b0, 1'b1, 8'hC3);

        // Back-to-back with start held high.
        in_bits = 8'hFF; match_bits = 8'hFF; start = 1'b1; cyc = 0;
        tick;
        while (!done && cyc < 200) begin tick; cyc++; end
        check("b2b_first_done", 64'(done), 64'(1));
        check("b2b_first_result", 64'(result_bits), 64'(8'hFF));
        check("b2b_busy_drop", 64'(busy), 64'(0));
        in_bits = 8'h00; match_bits = 8'h00;
        tick;
        check("b2b_second_accept", 64'(busy), 64'(1));
        start = 1'b0; cyc = 0; nd = 0;
        while (busy && cyc < 200) begin tick; cyc++; if (done) nd++; end
        check("b2b_second_done", 64'(nd), 64'(1));
        check("b2b_second_result", 64'(result_bits), 64'(8'h00));
        bad = 1'b0;
        repeat (5) begin tick; if (busy || done) bad = 1'b1; end
        check("b2b_no_extra", 64'(bad), 64'(0));

        // Illegal rail on cell 0 once the empty wavefront is launched.
        in_bits = 8'h96; match_bits = 8'h96; start = 1'b1;
        tick;
        start = 1'b0; cyc = 0; nd = 0; saw = 1'b0; inj_c = -1; err_c = -1;
        while (busy && cyc < 2000) begin
            tick; cyc++;
            if (done) nd++;
            if (error && err_c < 0) err_c = cyc;
            if (blk_in != '0) saw = 1'b1;
            else if (saw && !inj_illegal) begin inj_illegal = 1'b1; inj_c = cyc; end
        end
        inj_illegal = 1'b0;
        check("illegal_error", 64'(error), 64'(1));
        check("illegal_no_done", 64'(nd), 64'(0));
        check("illegal_result", 64'(result_bits), 64'(8'h96));
        check_range("illegal_latency", err_c - inj_c, 1, 3);
        last_res = 8'h96;

        // Randomized transactions against the outcome model.
        for (int k = 0; k < 20; k++) begin
            iv = W'($urandom);
            mv = ($urandom_range(0, 4) == 0) ? iv ^ W'(1 << $urandom_range(0, 7)) : iv;
            dr = 1'($urandom_range(0, 1));
            ok = (mv == iv);
            if (ok) last_res = iv;
            expect_txn($sformatf("rnd%0d", k), iv, mv, dr, ok, last_res);
        end

        // Reset in the middle of WAIT_FULL.
        expect_txn("pre_mid", 8'h81, 8'h81, 1'b0, 1'b1, 8'h81);
        hold_empty = 8'h08;
        in_bits = 8'h42; match_bits = 8'h42; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (20) tick;
        check("mid_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_rails", 64'({blk_in, blk_match}), 64'(0));
        check("mid_result", 64'(result_bits), 64'(0));
        check("mid_blk_reset", 64'(blk_reset), 64'(0));
        hold_empty = '0;
        repeat (3) tick;
        check("mid_stays_idle", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
